// File: rtl/jelly_rtos_pkg.sv
// Shared RTOS package: default widths and id/priority/time typedefs used by the
// timeout queue, ready queue and semaphore blocks.
package jelly_rtos_pkg;

  localparam int DEFAULT_TASKS        = 16;
  localparam int DEFAULT_TSKID_WIDTH  = $clog2(DEFAULT_TASKS);
  localparam int DEFAULT_TSKPRI_WIDTH = 4;
  localparam int DEFAULT_RELTIM_WIDTH = 32;

  typedef logic [DEFAULT_TSKID_WIDTH-1:0]  tskid_t;
  typedef logic [DEFAULT_TSKPRI_WIDTH-1:0] tskpri_t;
  typedef logic [DEFAULT_RELTIM_WIDTH-1:0] reltim_t;

endpackage

// File: rtl/jelly_rtos_first_one.sv
// Lowest-set-bit encoder: returns the index of the lowest set bit and a found flag.
module jelly_rtos_first_one #(
  parameter int WIDTH     = 16,
  parameter int IDX_WIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     vec_i,
  output logic [IDX_WIDTH-1:0] index_o,
  output logic                 found_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    index_o = '0;
    found_o = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        index_o = IDX_WIDTH'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jelly_rtos_timeout_queue.sv
// Per-task timeout engine: one countdown slot per task, expired tasks streamed out
// lowest id first. Optional readback port enabled by JELLY_RTOS_TIMEOUT_QUERY_EN.
module jelly_rtos_timeout_queue
  import jelly_rtos_pkg::*;
#(
  parameter int TASKS        = DEFAULT_TASKS,
  parameter int TSKPRI_WIDTH = DEFAULT_TSKPRI_WIDTH,
  parameter int RELTIM_WIDTH = DEFAULT_RELTIM_WIDTH,
  parameter int TSKID_WIDTH  = $clog2(TASKS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cke,
  input  logic                    tick,
  input  logic [TSKID_WIDTH-1:0]  set_tskid,
  input  logic [TSKPRI_WIDTH-1:0] set_tskpri,
  input  logic [RELTIM_WIDTH-1:0] set_reltim,
  input  logic                    set_valid,
  input  logic [TSKID_WIDTH-1:0]  cancel_tskid,
  input  logic                    cancel_valid,
  output logic [TSKID_WIDTH-1:0]  wakeup_tskid,
  output logic [TSKPRI_WIDTH-1:0] wakeup_tskpri,
  output logic                    wakeup_valid,
  input  logic                    wakeup_ready,
`ifdef JELLY_RTOS_TIMEOUT_QUERY_EN
  input  logic [TSKID_WIDTH-1:0]  query_tskid,
  input  logic                    query_valid,
  output logic [RELTIM_WIDTH-1:0] query_reltim,
  output logic                    query_ack,
`endif
  output logic [TASKS-1:0]        active
);

  logic [TASKS-1:0]        slotAct;
  logic [TASKS-1:0]        slotPend;
  logic [TSKPRI_WIDTH-1:0] slotPri [TASKS];
  logic [RELTIM_WIDTH-1:0] slotCnt [TASKS];

  logic                    outValid_q;
  logic [TSKID_WIDTH-1:0]  outId_q;
  logic [TSKPRI_WIDTH-1:0] outPri_q;

  logic [TSKID_WIDTH-1:0]  popIdx;
  logic                    popFound;
  logic                    loadOut;
  logic                    doPop;

  jelly_rtos_first_one #(
    .WIDTH     (TASKS),
    .IDX_WIDTH (TSKID_WIDTH)
  ) u_first_one (
    .vec_i   (slotPend),
    .index_o (popIdx),
    .found_o (popFound)
  );

  assign loadOut = !outValid_q || wakeup_ready;
  assign doPop   = loadOut && popFound;

  for (genvar i = 0; i < TASKS; i++) begin : g_slot
    logic                    act_q, act_d;
    logic                    pend_q, pend_d;
    logic [TSKPRI_WIDTH-1:0] pri_q, pri_d;
    logic [RELTIM_WIDTH-1:0] cnt_q, cnt_d;
    logic                    setHit, cancelHit, popHit;

    assign setHit    = set_valid && (set_tskid == TSKID_WIDTH'(i));
    assign cancelHit = cancel_valid && (cancel_tskid == TSKID_WIDTH'(i));
    assign popHit    = doPop && (popIdx == TSKID_WIDTH'(i));

    // Cancel beats set, and a set loads its value without this tick's decrement.
    always_comb begin
      act_d  = act_q;
      pend_d = pend_q;
      pri_d  = pri_q;
      cnt_d  = cnt_q;
      if (popHit) pend_d = 1'b0;
      if (cancelHit) begin
        act_d  = 1'b0;
        pend_d = 1'b0;
      end else if (setHit) begin
        pri_d = set_tskpri;
        if (set_reltim != '0) begin
          act_d  = 1'b1;
          pend_d = 1'b0;
          cnt_d  = set_reltim;
        end else begin
          act_d  = 1'b0;
          pend_d = 1'b1;
        end
      end else if (tick && act_q) begin
        if (cnt_q == RELTIM_WIDTH'(1)) begin
          act_d  = 1'b0;
          pend_d = 1'b1;
        end else begin
          cnt_d = cnt_q - RELTIM_WIDTH'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        act_q  <= 1'b0;
        pend_q <= 1'b0;
        pri_q  <= '0;
        cnt_q  <= '0;
      end else if (cke) begin
        act_q  <= act_d;
        pend_q <= pend_d;
        pri_q  <= pri_d;
        cnt_q  <= cnt_d;
      end
    end

    assign slotAct[i]  = act_q;
    assign slotPend[i] = pend_q;
    assign slotPri[i]  = pri_q;
    assign slotCnt[i]  = cnt_q;
  end

  // A presented entry holds until accepted, then the next pending slot replaces it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outValid_q <= 1'b0;
      outId_q    <= '0;
      outPri_q   <= '0;
    end else if (cke && loadOut) begin
      outValid_q <= popFound;
      if (popFound) begin
        outId_q  <= popIdx;
        outPri_q <= slotPri[popIdx];
      end
    end
  end

  assign wakeup_valid  = outValid_q;
  assign wakeup_tskid  = outId_q;
  assign wakeup_tskpri = outPri_q;
  assign active        = slotAct;

`ifdef JELLY_RTOS_TIMEOUT_QUERY_EN
  logic                    queryAck_q;
  logic [RELTIM_WIDTH-1:0] queryReltim_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      queryAck_q    <= 1'b0;
      queryReltim_q <= '0;
    end else if (cke) begin
      queryAck_q    <= query_valid;
      queryReltim_q <= slotAct[query_tskid] ? slotCnt[query_tskid] : '0;
    end
  end

  assign query_ack    = queryAck_q;
  assign query_reltim = queryReltim_q;
`endif

endmodule

// File: tb/tb_jelly_rtos_timeout_queue.sv
// Self-checking bench for the timeout queue: expected wakeups are queued when the
// stimulus that causes them is driven and compared as the DUT presents them.
module tb_jelly_rtos_timeout_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cke;
  logic        tick;
  logic [3:0]  set_tskid;
  logic [3:0]  set_tskpri;
  logic [31:0] set_reltim;
  logic        set_valid;
  logic [3:0]  cancel_tskid;
  logic        cancel_valid;
  logic [3:0]  wakeup_tskid;
  logic [3:0]  wakeup_tskpri;
  logic        wakeup_valid;
  logic        wakeup_ready;
  logic [15:0] active;

  int checks = 0;
  int errors = 0;
  logic [7:0] sbQ[$];
  logic [7:0] expEntry;

  jelly_rtos_timeout_queue dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cke           (cke),
    .tick          (tick),
    .set_tskid     (set_tskid),
    .set_tskpri    (set_tskpri),
    .set_reltim    (set_reltim),
    .set_valid     (set_valid),
    .cancel_tskid  (cancel_tskid),
    .cancel_valid  (cancel_valid),
    .wakeup_tskid  (wakeup_tskid),
    .wakeup_tskpri (wakeup_tskpri),
    .wakeup_valid  (wakeup_valid),
    .wakeup_ready  (wakeup_ready),
    .active        (active)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doSet(input logic [3:0] id, input logic [3:0] pri, input logic [31:0] rel);
    set_valid  = 1'b1;
    set_tskid  = id;
    set_tskpri = pri;
    set_reltim = rel;
    step();
    set_valid  = 1'b0;
  endtask

  task automatic doCancel(input logic [3:0] id);
    cancel_valid = 1'b1;
    cancel_tskid = id;
    step();
    cancel_valid = 1'b0;
  endtask

  task automatic doTick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (wakeup_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid actual=%b expected=0", wakeup_valid);
    end
    checks++;
    if (wakeup_tskid !== 4'd0) begin
      errors++; $display("[TB] FAIL reset_tskid actual=%h expected=0", wakeup_tskid);
    end
    checks++;
    if (wakeup_tskpri !== 4'd0) begin
      errors++; $display("[TB] FAIL reset_tskpri actual=%h expected=0", wakeup_tskpri);
    end
    checks++;
    if (active !== 16'h0000) begin
      errors++; $display("[TB] FAIL reset_active actual=%h expected=0000", active);
    end
  endtask

  task automatic test_single_expiry();
    doSet(4'd3, 4'd9, 32'd2);
    checks++;
    if (active !== 16'h0008) begin
      errors++; $display("[TB] FAIL single_armed actual=%h expected=0008", active);
    end
    doTick();
    repeat (4) step();
    checks++;
    if (wakeup_valid !== 1'b0 || active !== 16'h0008) begin
      errors++; $display("[TB] FAIL single_early actual=%b/%h expected=0/0008", wakeup_valid, active);
    end
    sbQ.push_back({4'd3, 4'd9});
    doTick();
    checks++;
    if (active !== 16'h0000 || wakeup_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL single_pending actual=%h/%b expected=0000/0", active, wakeup_valid);
    end
    step();
    checks++;
    if (wakeup_valid !== 1'b1 || sbQ.size() == 0) begin
      errors++; $display("[TB] FAIL single_valid actual=%b expected=1", wakeup_valid);
    end else begin
      expEntry = sbQ.pop_front();
      checks++;
      if ({wakeup_tskid, wakeup_tskpri} !== expEntry) begin
        errors++; $display("[TB] FAIL single_data actual=%h expected=%h", {wakeup_tskid, wakeup_tskpri}, expEntry);
      end
    end
    step();
    checks++;
    if (wakeup_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL single_drop actual=%b expected=0", wakeup_valid);
    end
  endtask

  task automatic test_multi_expiry();
    doSet(4'd7, 4'd1, 32'd1);
    doSet(4'd2, 4'd2, 32'd1);
    doSet(4'd5, 4'd3, 32'd1);
    checks++;
    if (active !== 16'h00A4) begin
      errors++; $display("[TB] FAIL multi_armed actual=%h expected=00a4", active);
    end
    sbQ.push_back({4'd2, 4'd2});
    sbQ.push_back({4'd5, 4'd3});
    sbQ.push_back({4'd7, 4'd1});
    doTick();
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (wakeup_valid !== 1'b1 || sbQ.size() == 0) begin
        errors++; $display("[TB] FAIL multi_valid%0d actual=%b expected=1", k, wakeup_valid);
      end else begin
        expEntry = sbQ.pop_front();
        if ({wakeup_tskid, wakeup_tskpri} !== expEntry) begin
          errors++; $display("[TB] FAIL multi_data%0d actual=%h expected=%h", k, {wakeup_tskid, wakeup_tskpri}, expEntry);
        end
      end
    end
    step();
    checks++;
    if (wakeup_valid !== 1'b0 || sbQ.size() != 0) begin
      errors++; $display("[TB] FAIL multi_drain actual=%b/%0d expected=0/0", wakeup_valid, sbQ.size());
    end
  endtask

  task automatic test_cancel();
    int spurious = 0;
    doSet(4'd4, 4'd5, 32'd3);
    doTick();
    doTick();
    doCancel(4'd4);
    checks++;
    if (active !== 16'h0000) begin
      errors++; $display("[TB] FAIL cancel_active actual=%h expected=0000", active);
    end
    doTick();
    doTick();
    repeat (4) begin
      if (wakeup_valid) spurious++;
      step();
    end
    set_valid = 1'b1; set_tskid = 4'd4; set_tskpri = 4'd5; set_reltim = 32'd1;
    cancel_valid = 1'b1; cancel_tskid = 4'd4;
    step();
    set_valid = 1'b0; cancel_valid = 1'b0;
    checks++;
    if (active !== 16'h0000) begin
      errors++; $display("[TB] FAIL setcancel_same actual=%h expected=0000", active);
    end
    doTick();
    repeat (3) begin
      if (wakeup_valid) spurious++;
      step();
    end
    checks++;
    if (spurious != 0) begin
      errors++; $display("[TB] FAIL cancel_nowake actual=%0d expected=0", spurious);
    end
    set_valid = 1'b1; set_tskid = 4'd6; set_tskpri = 4'd5; set_reltim = 32'd5;
    cancel_valid = 1'b1; cancel_tskid = 4'd4;
    step();
    set_valid = 1'b0; cancel_valid = 1'b0;
    checks++;
    if (active !== 16'h0040) begin
      errors++; $display("[TB] FAIL setcancel_diff actual=%h expected=0040", active);
    end
    doCancel(4'd6);
  endtask

  task automatic test_stall();
    int unstable = 0;
    wakeup_ready = 1'b0;
    sbQ.push_back({4'd1, 4'd5});
    doSet(4'd1, 4'd5, 32'd0);
    checks++;
    if (wakeup_valid !== 1'b0 || active !== 16'h0000) begin
      errors++; $display("[TB] FAIL stall_first actual=%b/%h expected=0/0000", wakeup_valid, active);
    end
    step();
    repeat (10) begin
      if (wakeup_valid !== 1'b1 || {wakeup_tskid, wakeup_tskpri} !== sbQ[0]) unstable++;
      step();
    end
    checks++;
    if (unstable != 0) begin
      errors++; $display("[TB] FAIL stall_hold actual=%0d expected=0", unstable);
    end
    wakeup_ready = 1'b1;
    #1;
    checks++;
    if (wakeup_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL stall_accept actual=%b expected=1", wakeup_valid);
    end else begin
      expEntry = sbQ.pop_front();
      if ({wakeup_tskid, wakeup_tskpri} !== expEntry) begin
        errors++; $display("[TB] FAIL stall_data actual=%h expected=%h", {wakeup_tskid, wakeup_tskpri}, expEntry);
      end
    end
    step();
    checks++;
    if (wakeup_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_drop actual=%b expected=0", wakeup_valid);
    end
  endtask

  task automatic test_cke();
    cke = 1'b0;
    set_valid = 1'b1; set_tskid = 4'd8; set_tskpri = 4'd2; set_reltim = 32'd1;
    step();
    set_valid = 1'b0;
    cke = 1'b1;
    step();
    checks++;
    if (active !== 16'h0000 || wakeup_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL cke_hold actual=%h/%b expected=0000/0", active, wakeup_valid);
    end
  endtask

  task automatic test_rearm();
    doSet(4'd0, 4'd6, 32'hFFFF_FFFF);
    checks++;
    if (active !== 16'h0001) begin
      errors++; $display("[TB] FAIL rearm_armed actual=%h expected=0001", active);
    end
    set_valid = 1'b1; set_tskid = 4'd0; set_tskpri = 4'd11; set_reltim = 32'd1;
    tick = 1'b1;
    step();
    set_valid = 1'b0; tick = 1'b0;
    checks++;
    if (active !== 16'h0001 || wakeup_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL rearm_load actual=%h/%b expected=0001/0", active, wakeup_valid);
    end
    step();
    sbQ.push_back({4'd0, 4'd11});
    doTick();
    checks++;
    if (active !== 16'h0000) begin
      errors++; $display("[TB] FAIL rearm_expire actual=%h expected=0000", active);
    end
    step();
    checks++;
    if (wakeup_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL rearm_valid actual=%b expected=1", wakeup_valid);
    end else begin
      expEntry = sbQ.pop_front();
      if ({wakeup_tskid, wakeup_tskpri} !== expEntry) begin
        errors++; $display("[TB] FAIL rearm_data actual=%h expected=%h", {wakeup_tskid, wakeup_tskpri}, expEntry);
      end
    end
    step();
  endtask

  task automatic test_reset_mid();
    int late = 0;
    wakeup_ready = 1'b0;
    doSet(4'd9, 4'd2, 32'd0);
    doSet(4'd10, 4'd3, 32'd0);
    doSet(4'd11, 4'd4, 32'd0);
    doSet(4'd12, 4'd1, 32'd2);
    checks++;
    if (wakeup_valid !== 1'b1 || wakeup_tskid !== 4'd9 || active !== 16'h1000) begin
      errors++; $display("[TB] FAIL mid_pre actual=%b/%h/%h expected=1/9/1000", wakeup_valid, wakeup_tskid, active);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (wakeup_valid !== 1'b0 || wakeup_tskid !== 4'd0 || wakeup_tskpri !== 4'd0 || active !== 16'h0000) begin
      errors++; $display("[TB] FAIL mid_reset actual=%b/%h/%h/%h expected=0/0/0/0000",
                         wakeup_valid, wakeup_tskid, wakeup_tskpri, active);
    end
    step();
    reset_n = 1'b1;
    wakeup_ready = 1'b1;
    repeat (3) doTick();
    repeat (5) begin
      if (wakeup_valid) late++;
      step();
    end
    checks++;
    if (late != 0 || active !== 16'h0000) begin
      errors++; $display("[TB] FAIL mid_after actual=%0d/%h expected=0/0000", late, active);
    end
  endtask

  initial begin
    reset_n = 1'b0; cke = 1'b1; tick = 1'b0;
    set_tskid = '0; set_tskpri = '0; set_reltim = '0; set_valid = 1'b0;
    cancel_tskid = '0; cancel_valid = 1'b0; wakeup_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    test_reset();
    test_single_expiry();
    test_multi_expiry();
    test_cancel();
    test_stall();
    test_cke();
    test_rearm();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jelly_rtos_timeout_queue.md
# jelly_rtos_timeout_queue

Per-task timeout engine for the hardware RTOS. Holds one relative-time countdown slot per task, decrements every armed slot on each system tick, and emits expired tasks one per cycle as a (task id, priority) stream. It sits directly upstream of the ready queue: its output drives the ready-queue add port (op = add) through the RTOS arbiter. Tasks blocked with timeouts on semaphores or event flags, and tasks in a delay, are released this way.

## Interface
- TASKS, 16, number of task slots
- TSKPRI_WIDTH, 4, task priority width
- RELTIM_WIDTH, 32, relative-time counter width, in ticks
- TSKID_WIDTH, $clog2(TASKS), task id width
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cke  in  1  clock enable; when low all state holds and handshakes stall
- tick  in  1  one-cycle system tick pulse
- set_tskid / set_tskpri / set_reltim  in  TSKID_WIDTH / TSKPRI_WIDTH / RELTIM_WIDTH  arm request
- set_valid  in  1  arm strobe, always accepted
- cancel_tskid  in  TSKID_WIDTH  slot to disarm
- cancel_valid  in  1  cancel strobe, always accepted
- wakeup_tskid / wakeup_tskpri  out  TSKID_WIDTH / TSKPRI_WIDTH  expired task
- wakeup_valid  out  1  expired-task strobe
- wakeup_ready  in  1  downstream accept
- active  out  TASKS  per-slot armed bitmap, registered

## Operation
- Per slot: active bit, pending bit, pri register, cnt[RELTIM_WIDTH].
- set, reltim > 0: active = 1, pending = 0, cnt = reltim, pri = set_tskpri. Arming an already active or pending slot restarts it.
- set, reltim = 0: active = 0, pending = 1 (immediate expiry).
- cancel: active = 0, pending = 0.
- set and cancel on the same id in the same cycle: cancel wins. Different ids: both take effect.
- tick: every active slot not being set or cancelled this cycle does one of two things:
  - cnt == 1: active = 0, pending = 1.
  - otherwise: cnt = cnt - 1.
- set and tick on the same id: the set value loads undecremented.
- cnt is never 0 while active, so there is no wrap.
- Output register: when empty, or being consumed (valid && ready), it loads the lowest-numbered pending slot. That slot's pending bit clears in the same cycle.
- A committed output entry is not withdrawn by a later cancel or set of that id. The consumer must tolerate stale wakeups.
- Several slots expiring on one tick drain in ascending id order, one per accepted cycle.

## Timing
- Reset values: wakeup_valid = 0, wakeup_tskid = 0, wakeup_tskpri = 0, active = 0; all slot state cleared.
- reset_n asserted mid-operation discards all armed, pending and in-flight entries immediately.
- set or cancel at cycle N: active reflects it at N+1.
- tick at N with cnt == 1: pending at N+1, wakeup_valid at N+2 (if the output register is free).
- set with reltim = 0 at N: wakeup_valid at N+2.
- Throughput: one wakeup per cycle with wakeup_ready held high.
- wakeup_valid, once high, holds with stable tskid/pri until accepted (valid && ready && cke).
- cke low: no state change. A tick arriving during cke low is lost; the tick source must qualify with cke.

## Configuration
- Macro JELLY_RTOS_TIMEOUT_QUERY_EN.
- Defined: adds ports query_tskid (in, TSKID_WIDTH), query_valid (in, 1), query_reltim (out, RELTIM_WIDTH), query_ack (out, 1).
  - query_reltim = cnt of the slot, or 0 if not active.
  - Registered: ack and data appear one cycle after query_valid.
  - Reset values: query_ack = 0, query_reltim = 0.
- Undefined: the ports are absent and no read mux is built.

## Structure
- Shared package jelly_rtos_pkg holds the TASKS / TSKID_WIDTH / TSKPRI_WIDTH / RELTIM_WIDTH defaults and typedefs tskid_t, tskpri_t, reltim_t. The same package serves the ready queue and semaphores.
- One sub-module: jelly_rtos_first_one, a parameterised lowest-set-bit encoder.
  - Inputs: TASKS-bit vector.
  - Outputs: index and found flag.
  - Purely combinational.
- Slot array written as a generate loop inside the top module.

## Test plan
- Set id 3, reltim 2; pulse tick at T0, T5 → wakeup_valid at T5+2 with tskid 3 and set pri; active[3] = 0 afterwards.
- Set ids 7, 2, 5 all reltim 1, tick once, wakeup_ready = 1 → three wakeups on consecutive cycles, ids 2, 5, 7.
- Set id 4 reltim 3, cancel id 4 before the third tick → no wakeup, active = 0. Same-cycle set + cancel on id 4 → slot stays disarmed.
- Set id 1 reltim 0 with wakeup_ready = 0 for 10 cycles → wakeup_valid high, id 1 stable throughout; accepted on the ready rise, then valid drops.
- Set id 0 with reltim = 2^RELTIM_WIDTH-1 and re-arm with reltim 1 on a tick cycle → cnt = 1, expires on the next tick.
- Assert reset_n low while two wakeups are pending and one is presented → all outputs 0 immediately; no wakeups after release.
